uart_loader: RTL and testbench

UART_LOADER -- requirements
Module: uart_loader

---
 rtl/uart_loader.sv | 154 +++++++++++++++
 tb/tb_uart_loader.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/uart_loader.sv
// uart_loader: UART 8N1 frame receiver that writes a length-prefixed word image into data memory.
module uart_loader #(
    parameter int DW      = 16,
    parameter int AW      = 16,
    parameter int DP      = 1024,
    parameter int CLK_DIV = 868
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          rx,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_din,
    output logic          mem_we,
    output logic          cpu_hold,
    output logic          load_done,
    output logic          err
);
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_t;
    typedef enum logic [2:0] {F_HDR, F_LENH, F_LENL, F_WHI, F_WLO} fr_t;
    localparam int BW = $clog2(CLK_DIV);
    localparam logic [BW-1:0] L_FULL = BW'(CLK_DIV - 1);
    localparam logic [BW-1:0] L_HALF = BW'(CLK_DIV / 2 - 1);
    logic          r_rx_meta, r_rx_sync;
    rx_t           r_rx_st;
    logic [BW-1:0] r_baud;
    logic [2:0]    r_bit;
    logic [7:0]    r_shift, r_byte;
    logic          r_byte_valid, r_frm_err;
    fr_t           r_fs;
    logic [15:0]   r_len, r_idx;
    logic [7:0]    r_hi;
    logic [15:0]   w_len, w_idx_nx;
    assign w_len    = {r_len[15:8], r_byte};
    assign w_idx_nx = r_idx + 16'd1;
    // Byte receiver: start bit re-checked at mid-bit, data and stop sampled at bit centres.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_meta    <= 1'b1;
            r_rx_sync    <= 1'b1;
            r_rx_st      <= RX_IDLE;
            r_baud       <= '0;
            r_bit        <= '0;
            r_shift      <= '0;
            r_byte       <= '0;
            r_byte_valid <= 1'b0;
            r_frm_err    <= 1'b0;
        end else begin
            r_rx_meta    <= rx;
            r_rx_sync    <= r_rx_meta;
            r_byte_valid <= 1'b0;
            r_frm_err    <= 1'b0;
            case (r_rx_st)
                RX_IDLE: begin
                    r_baud <= '0;
                    if (!r_rx_sync) r_rx_st <= RX_START;
                end
                RX_START: begin
                    if (r_baud == L_HALF) begin
                        r_baud  <= '0;
                        r_bit   <= '0;
                        r_rx_st <= r_rx_sync ? RX_IDLE : RX_DATA;
                    end else r_baud <= r_baud + 1'b1;
                end
                RX_DATA: begin
                    if (r_baud == L_FULL) begin
                        r_baud  <= '0;
                        r_shift <= {r_rx_sync, r_shift[7:1]};
                        r_bit   <= r_bit + 3'd1;
                        if (r_bit == 3'd7) r_rx_st <= RX_STOP;
                    end else r_baud <= r_baud + 1'b1;
                end
                RX_STOP: begin
                    if (r_baud == L_FULL) begin
                        r_baud       <= '0;
                        r_byte       <= r_shift;
                        r_byte_valid <= r_rx_sync;
                        r_frm_err    <= !r_rx_sync;
                        r_rx_st      <= RX_IDLE;
                    end else r_baud <= r_baud + 1'b1;
                end
                default: r_rx_st <= RX_IDLE;
            endcase
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fs      <= F_HDR;
            r_len     <= '0;
            r_idx     <= '0;
            r_hi      <= '0;
            mem_addr  <= '0;
            mem_din   <= '0;
            mem_we    <= 1'b0;
            cpu_hold  <= 1'b0;
            load_done <= 1'b0;
            err       <= 1'b0;
        end else begin
            mem_we <= 1'b0;
            err    <= 1'b0;
            if (r_frm_err) begin
                err <= 1'b1;
                if (r_fs != F_HDR) begin
                    cpu_hold <= 1'b0;
                    r_fs     <= F_HDR;
                end
            end else if (r_byte_valid) begin
                case (r_fs)
                    F_HDR: begin
                        if (r_byte == 8'hA5) begin
                            r_fs      <= F_LENH;
                            cpu_hold  <= 1'b1;
                            load_done <= 1'b0;
                        end
                    end
                    F_LENH: begin
                        r_len[15:8] <= r_byte;
                        r_fs        <= F_LENL;
                    end
                    F_LENL: begin
                        r_len[7:0] <= r_byte;
                        if (w_len == 16'd0) begin
                            load_done <= 1'b1;
                            cpu_hold  <= 1'b0;
                            r_fs      <= F_HDR;
                        end else if ({16'd0, w_len} > DP) begin
                            err      <= 1'b1;
                            cpu_hold <= 1'b0;
                            r_fs     <= F_HDR;
                        end else begin
                            r_idx <= '0;
                            r_fs  <= F_WHI;
                        end
                    end
                    F_WHI: begin
                        r_hi <= r_byte;
                        r_fs <= F_WLO;
                    end
                    F_WLO: begin
                        mem_we   <= 1'b1;
                        mem_addr <= AW'(r_idx);
                        mem_din  <= DW'({r_hi, r_byte});
                        r_idx    <= w_idx_nx;
                        if (w_idx_nx == r_len) begin
                            load_done <= 1'b1;
                            cpu_hold  <= 1'b0;
                            r_fs      <= F_HDR;
                        end else r_fs <= F_WHI;
                    end
                    default: r_fs <= F_HDR;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_uart_loader.sv
// tb_uart_loader: scoreboard bench driving UART frames into uart_loader and checking memory writes and flags.
module tb_uart_loader;
    localparam int CD = 8;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rx  = 1'b1;
    logic [15:0] mem_addr, mem_din;
    logic        mem_we, cpu_hold, load_done, err;
    int          n_checks = 0;
    int          n_fail   = 0;
    int          n_err    = 0;
    logic [31:0] exp_q[$];

    uart_loader #(.DW(16), .AW(16), .DP(1024), .CLK_DIV(CD)) dut (
        .clk(clk), .rst(rst), .rx(rx),
        .mem_addr(mem_addr), .mem_din(mem_din), .mem_we(mem_we),
        .cpu_hold(cpu_hold), .load_done(load_done), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (err) n_err++;
        if (mem_we) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_write: got addr %h data %h expected no write", mem_addr, mem_din);
            end else chk("write", {mem_addr, mem_din}, exp_q.pop_front());
        end
    end

    task automatic send_byte(input logic [7:0] b, input logic stop);
        rx = 1'b0;
        repeat (CD) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CD) @(negedge clk);
        end
        rx = stop;
        repeat (CD) @(negedge clk);
        rx = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    // Reference model: a well-formed frame of n words writes word i to address i.
    task automatic send_frame(input logic [15:0] words[$]);
        logic [15:0] n;
        n = 16'(words.size());
        send_byte(8'hA5, 1'b1);
        send_byte(n[15:8], 1'b1);
        send_byte(n[7:0], 1'b1);
        for (int i = 0; i < words.size(); i++) begin
            exp_q.push_back({16'(i), words[i]});
            send_byte(words[i][15:8], 1'b1);
            send_byte(words[i][7:0], 1'b1);
        end
    endtask

    initial begin
        logic [15:0] w[$];
        int          e0;
        logic [7:0]  g;
        repeat (3) @(negedge clk);
        chk("rst_addr", 32'(mem_addr), 0);
        chk("rst_din", 32'(mem_din), 0);
        chk("rst_we", 32'(mem_we), 0);
        chk("rst_hold", 32'(cpu_hold), 0);
        chk("rst_done", 32'(load_done), 0);
        chk("rst_err", 32'(err), 0);
        rst = 1'b0;
        repeat (1000) @(negedge clk);
        chk("idle_err", 32'(n_err), 0);
        chk("idle_hold", 32'(cpu_hold), 0);

        // two-word load
        e0 = n_err;
        send_byte(8'hA5, 1'b1);
        chk("hdr_hold", 32'(cpu_hold), 1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h02, 1'b1);
        exp_q.push_back({16'h0000, 16'h1234});
        exp_q.push_back({16'h0001, 16'hABCD});
        send_byte(8'h12, 1'b1);
        send_byte(8'h34, 1'b1);
        chk("mid_hold", 32'(cpu_hold), 1);
        send_byte(8'hAB, 1'b1);
        send_byte(8'hCD, 1'b1);
        chk("two_pending", 32'(exp_q.size()), 0);
        chk("two_done", 32'(load_done), 1);
        chk("two_hold", 32'(cpu_hold), 0);
        chk("two_err", 32'(n_err - e0), 0);

        // bad header ignored
        e0 = n_err;
        send_byte(8'h5A, 1'b1);
        chk("bad_hdr_hold", 32'(cpu_hold), 0);
        w = '{16'hBEEF};
        send_frame(w);
        chk("badhdr_pending", 32'(exp_q.size()), 0);
        chk("badhdr_done", 32'(load_done), 1);
        chk("badhdr_err", 32'(n_err - e0), 0);

        // oversize length
        e0 = n_err;
        send_byte(8'hA5, 1'b1);
        chk("over_done_cleared", 32'(load_done), 0);
        send_byte(8'h04, 1'b1);
        send_byte(8'h01, 1'b1);
        chk("over_err", 32'(n_err - e0), 1);
        chk("over_hold", 32'(cpu_hold), 0);
        w = '{16'h0F0F};
        send_frame(w);
        chk("over_recover", 32'(exp_q.size()), 0);
        chk("over_recover_done", 32'(load_done), 1);

        // framing error mid-frame
        e0 = n_err;
        send_byte(8'hA5, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h02, 1'b1);
        exp_q.push_back({16'h0000, 16'h1122});
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        send_byte(8'h33, 1'b1);
        send_byte(8'h44, 1'b0);
        repeat (20) @(negedge clk);
        chk("frm_pending", 32'(exp_q.size()), 0);
        chk("frm_err", 32'(n_err - e0), 1);
        chk("frm_hold", 32'(cpu_hold), 0);
        chk("frm_done", 32'(load_done), 0);

        // framing error while waiting for a header leaves loader idle
        e0 = n_err;
        send_byte(8'hA5, 1'b0);
        repeat (20) @(negedge clk);
        chk("hdr_frm_err", 32'(n_err - e0), 1);
        chk("hdr_frm_hold", 32'(cpu_hold), 0);

        // mid-frame reset, then glitch
        e0 = n_err;
        send_byte(8'hA5, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h03, 1'b1);
        exp_q.push_back({16'h0000, 16'h0001});
        send_byte(8'h00, 1'b1);
        send_byte(8'h01, 1'b1);
        chk("pre_rst_hold", 32'(cpu_hold), 1);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("mrst_hold", 32'(cpu_hold), 0);
        chk("mrst_done", 32'(load_done), 0);
        w = '{16'h5566};
        send_frame(w);
        chk("mrst_pending", 32'(exp_q.size()), 0);
        chk("mrst_newdone", 32'(load_done), 1);
        rx = 1'b0;
        repeat (2) @(negedge clk);
        rx = 1'b1;
        repeat (40) @(negedge clk);
        chk("glitch_err", 32'(n_err - e0), 0);
        chk("glitch_hold", 32'(cpu_hold), 0);
        chk("glitch_done", 32'(load_done), 1);

        // randomized frames, optional junk byte before header
        for (int f = 0; f < 8; f++) begin
            e0 = n_err;
            if ($urandom_range(0, 1) == 1) begin
                g = 8'($urandom_range(0, 255));
                if (g == 8'hA5) g = 8'h00;
                send_byte(g, 1'b1);
            end
            w.delete();
            for (int i = 0; i < int'($urandom_range(0, 4)); i++) w.push_back(16'($urandom));
            send_frame(w);
            chk("rnd_pending", 32'(exp_q.size()), 0);
            chk("rnd_done", 32'(load_done), 1);
            chk("rnd_hold", 32'(cpu_hold), 0);
            chk("rnd_err", 32'(n_err - e0), 0);
        end
        repeat (20) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
